fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller directly downstream of the program counter.
- Consumes the PC value, reads program memory over a req/ack handshake, and assembles 1- or 2-byte instructions into an output register for the decoder.
- Drives the counter's countEnable / nLoadEnable / load-value inputs to advance or redirect the PC.

Parameters:
ADDR_WIDTH, 8, PC / memory address width
DATA_WIDTH, 8, program memory word width
TIMEOUT_CYCLES, 15, max wait for mem_ack before error (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
nReset  input  1  asynchronous, active-low reset
pc_in  input  ADDR_WIDTH  current PC (counter output)
pc_countEnable  output  1  advance PC by 1 at next edge
pc_nLoadEnable  output  1  active-low PC load strobe
pc_loadValue  output  ADDR_WIDTH  PC load value
mem_addr  output  ADDR_WIDTH  program memory address
mem_req  output  1  memory read request
mem_ack  input  1  read data valid this cycle
mem_data  input  DATA_WIDTH  read data
redirect_valid  input  1  jump request from execute
redirect_addr  input  ADDR_WIDTH  jump target
ir_valid  output  1  instruction available
ir_ready  input  1  decoder accepts instruction
ir_op  output  DATA_WIDTH  opcode byte
ir_imm  output  DATA_WIDTH  immediate byte (0 for short form)
ir_long  output  1  instruction is 2-byte form
fetch_error  output  1  sticky timeout flag (0 without macro)

Behaviour:
- Reset: nReset is asynchronous, active-low; clock is clk. During reset, state = IDLE; ir_valid=0, ir_op=0, ir_imm=0, ir_long=0, fetch_error=0.
- States: IDLE, FETCH0, FETCH1, OUT.
- Combinational outputs:
  - mem_req=1 in FETCH0/FETCH1; mem_addr=pc_in.
  - pc_countEnable = mem_ack & mem_req & !redirect_valid.
  - pc_nLoadEnable = !redirect_valid; pc_loadValue = redirect_addr.
  - In IDLE/OUT, mem_req=0 and pc_countEnable=0.
- IDLE -> FETCH0 unconditionally on the first edge after reset release.
- FETCH0, on ack:
  - Latch ir_op=mem_data; PC increments at the same edge.
  - If mem_data[DATA_WIDTH-1:DATA_WIDTH-2]==2'b11: ir_long=1, go to FETCH1.
  - Else: ir_imm=0, ir_long=0, go to OUT.
- FETCH1: pc_in is already incremented. On ack, latch ir_imm=mem_data, PC increments, go to OUT.
- OUT:
  - ir_valid=1; ir_op/ir_imm/ir_long held stable.
  - On ir_valid & ir_ready -> FETCH0; ir_valid drops next cycle.
  - Without ir_ready, hold indefinitely.
- Memory handshake:
  - mem_addr stable while mem_req=1 and no redirect.
  - ack may arrive in the same cycle as req (zero-wait memory).
  - Deassertion of mem_req without ack = cancel; memory must discard the request.
- Throughput: short instruction = 2 cycles minimum (FETCH0 + OUT); long instruction = 3 cycles.
- Redirect (priority over everything, any non-IDLE state):
  - PC loads redirect_addr at the edge; any in-flight fetch is abandoned.
  - Coincident mem_ack is ignored and no countEnable is issued.
  - ir_valid=0 next cycle; next state is FETCH0, which reads the new PC one cycle later.
- Redirect in IDLE: load still performed; state goes to FETCH0.
- Redirect coinciding with ir_valid & ir_ready: the instruction counts as consumed; redirect proceeds.
- PC wrap-around is owned by the counter; this block imposes no bound.
- Reset mid-fetch: immediate return to IDLE; mem_req drops asynchronously.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter, width $clog2(TIMEOUT_CYCLES+1), clears on entry to FETCH0/FETCH1 and on ack, and increments each cycle mem_req=1 without ack.
  - When the count reaches TIMEOUT_CYCLES, fetch_error sets (sticky until reset), state goes to IDLE and stays there; redirect is then ignored.
- Not defined: no counter; fetch_error tied 0; wait is unbounded.

Test Plan:
- Reset release, pc_in=8'h00, zero-wait memory returns 8'h12 -> mem_req asserts one cycle after release; countEnable pulses 1 cycle; ir_valid=1 with ir_op=8'h12, ir_imm=0, ir_long=0.
- Long instruction: memory returns 8'hC5 then 8'h3A with 2-cycle ack latency -> two countEnable pulses; ir_op=8'hC5, ir_imm=8'h3A, ir_long=1.
- Backpressure: ir_ready=0 for 5 cycles in OUT -> ir_valid and outputs stable; mem_req=0; no PC activity; accept on the 6th cycle -> FETCH0 next.
- Redirect to 8'h40 coincident with mem_ack in FETCH1 -> pc_nLoadEnable=0 with pc_loadValue=8'h40; countEnable=0; next fetch address 8'h40; ir_valid never asserted for the abandoned instruction.
- Async reset asserted mid-FETCH1 -> mem_req, ir_valid drop immediately; fetch restarts via IDLE.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=15, mem_ack held 0 -> fetch_error=1 after 15 waiting cycles; mem_req=0 thereafter; a later redirect_valid is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads 1- or 2-byte instructions from program memory
// and steers the PC counter. Define FETCH_TIMEOUT_EN to add the ack-timeout watchdog.
//   state  | meaning
//   IDLE   | after reset (or halted after a fetch timeout)
//   FETCH0 | requesting the opcode byte at pc_in
//   FETCH1 | requesting the immediate byte of a long instruction
//   OUT    | instruction presented to the decoder
module fetch_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_countEnable,
  output logic                  pc_nLoadEnable,
  output logic [ADDR_WIDTH-1:0] pc_loadValue,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_op,
  output logic [DATA_WIDTH-1:0] ir_imm,
  output logic                  ir_long,
  output logic                  fetch_error
);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, OUT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_q, op_d, imm_q, imm_d;
  logic                  long_q, long_d;
  logic                  redirect, ack, halted;

`ifdef FETCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYCLES);
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;

  assign halted      = err_q;
  assign fetch_error = err_q;
`else
  assign halted      = 1'b0;
  assign fetch_error = 1'b0;
`endif

  // After a timeout the block is frozen, so redirects must not touch the PC either.
  assign redirect       = redirect_valid & ~halted;
  assign mem_req        = (state_q == FETCH0) || (state_q == FETCH1);
  assign ack            = mem_ack & mem_req;
  assign pc_countEnable = ack & ~redirect;
  assign pc_nLoadEnable = ~redirect;
  assign pc_loadValue   = redirect_addr;
  assign mem_addr       = pc_in;
  assign ir_valid       = (state_q == OUT);
  assign ir_op          = op_q;
  assign ir_imm         = imm_q;
  assign ir_long        = long_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    long_d  = long_q;
    if (redirect) begin
      state_d = FETCH0;
    end else begin
      case (state_q)
        IDLE:   if (!halted) state_d = FETCH0;
        FETCH0: if (ack) begin
          op_d = mem_data;
          if (mem_data[DATA_WIDTH-1 -: 2] == 2'b11) begin
            long_d  = 1'b1;
            state_d = FETCH1;
          end else begin
            imm_d   = '0;
            long_d  = 1'b0;
            state_d = OUT;
          end
        end
        FETCH1: if (ack) begin
          imm_d   = mem_data;
          state_d = OUT;
        end
        OUT:    if (ir_ready) state_d = FETCH0;
        default: state_d = IDLE;
      endcase
    end
`ifdef FETCH_TIMEOUT_EN
    wait_d = wait_q;
    err_d  = err_q;
    if (!mem_req || ack || redirect) begin
      wait_d = '0;
    end else if (wait_q + 1'b1 == WAIT_MAX) begin
      wait_d  = '0;
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      wait_d = wait_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      long_q  <= long_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC counter and a
// program memory of programmable ack latency.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] pc_in;
  logic       pc_countEnable, pc_nLoadEnable;
  logic [7:0] pc_loadValue, mem_addr;
  logic       mem_req, mem_ack;
  logic [7:0] mem_data;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       ir_valid, ir_ready, ir_long, fetch_error;
  logic [7:0] ir_op, ir_imm;

  fetch_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .nReset(nReset), .pc_in(pc_in),
    .pc_countEnable(pc_countEnable), .pc_nLoadEnable(pc_nLoadEnable),
    .pc_loadValue(pc_loadValue), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_op(ir_op), .ir_imm(ir_imm), .ir_long(ir_long), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  logic [7:0] prog [256];
  int         lat, wcnt, ces, loads, n_checks, n_pass;
  bit         ack_en;

  // Program counter owned by the environment.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc_in <= 8'h00;
    end else if (!pc_nLoadEnable) begin
      pc_in <= pc_loadValue;
      loads <= loads + 1;
    end else if (pc_countEnable) begin
      pc_in <= pc_in + 8'h01;
      ces   <= ces + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic drive_mem();
    if (mem_req && ack_en && wcnt >= lat) begin
      mem_ack  = 1'b1;
      mem_data = prog[mem_addr];
      wcnt     = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt    = mem_req ? wcnt + 1 : 0;
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_mem();
      #1;
    end
  endtask

  int ce_snap;

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    prog[8'h00] = 8'h12;
    prog[8'h01] = 8'hC5; prog[8'h02] = 8'h3A;
    prog[8'h03] = 8'hC1; prog[8'h04] = 8'h55;
    prog[8'h10] = 8'h3C;
    prog[8'h40] = 8'h07;
    prog[8'h41] = 8'hC2; prog[8'h42] = 8'h99;
    n_checks = 0; n_pass = 0; ces = 0; loads = 0; wcnt = 0; lat = 0; ack_en = 1'b1;
    nReset = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
    mem_ack = 1'b0; mem_data = 8'h00;

    // reset state
    step(3);
    check("rst_req", mem_req, 1'b0);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_op", ir_op, 8'h00);
    check("rst_imm", ir_imm, 8'h00);
    check("rst_long", ir_long, 1'b0);
    check("rst_err", fetch_error, 1'b0);

    // short instruction, zero-wait memory
    nReset = 1'b1;
    step();
    check("s_req", mem_req, 1'b1);
    check("s_addr", mem_addr, 8'h00);
    check("s_ce", pc_countEnable, 1'b1);
    step();
    check("s_valid", ir_valid, 1'b1);
    check("s_op", ir_op, 8'h12);
    check("s_imm", ir_imm, 8'h00);
    check("s_long", ir_long, 1'b0);
    check("s_ces", ces, 1);

    // backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", ir_valid, 1'b1);
      check("bp_req", mem_req, 1'b0);
    end
    check("bp_op", ir_op, 8'h12);
    check("bp_ces", ces, 1);
    check("bp_pc", pc_in, 8'h01);

    // long instruction, ack latency 2
    lat = 2;
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("l_valid0", ir_valid, 1'b0);
    check("l_req", mem_req, 1'b1);
    check("l_addr0", mem_addr, 8'h01);
    check("l_ce_wait", pc_countEnable, 1'b0);
    step(2);
    check("l_ce0", pc_countEnable, 1'b1);
    step();
    check("l_valid1", ir_valid, 1'b0);
    check("l_addr1", mem_addr, 8'h02);
    check("l_long_f1", ir_long, 1'b1);
    step(2);
    check("l_ce1", pc_countEnable, 1'b1);
    step();
    check("l_valid", ir_valid, 1'b1);
    check("l_op", ir_op, 8'hC5);
    check("l_imm", ir_imm, 8'h3A);
    check("l_long", ir_long, 1'b1);
    check("l_ces", ces, 3);

    // redirect coincident with ack in FETCH1
    lat = 0;
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("r_valid0", ir_valid, 1'b0);
    step();
    check("r_addr_f1", mem_addr, 8'h04);
    redirect_valid = 1'b1; redirect_addr = 8'h40;
    #1;
    check("r_nload", pc_nLoadEnable, 1'b0);
    check("r_loadv", pc_loadValue, 8'h40);
    check("r_ce", pc_countEnable, 1'b0);
    ce_snap = ces;
    step();
    redirect_valid = 1'b0;
    check("r_valid1", ir_valid, 1'b0);
    check("r_addr", mem_addr, 8'h40);
    check("r_ces", ces, ce_snap);
    check("r_loads", loads, 1);
    step();
    check("r_valid", ir_valid, 1'b1);
    check("r_op", ir_op, 8'h07);
    check("r_long", ir_long, 1'b0);

    // async reset mid-FETCH1, then restart with a redirect while in IDLE
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    step();
    check("ar_req_pre", mem_req, 1'b1);
    check("ar_addr_pre", mem_addr, 8'h42);
    nReset = 1'b0;
    #1;
    check("ar_req", mem_req, 1'b0);
    check("ar_valid", ir_valid, 1'b0);
    check("ar_long", ir_long, 1'b0);
    step(2);
    redirect_valid = 1'b1; redirect_addr = 8'h10;
    nReset = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("ar_req_post", mem_req, 1'b1);
    check("ar_addr_post", mem_addr, 8'h10);
    step();
    check("ar_valid_post", ir_valid, 1'b1);
    check("ar_op_post", ir_op, 8'h3C);

    // memory never acks
    ack_en = 1'b0;
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    step(20);
`ifdef FETCH_TIMEOUT_EN
    check("to_err", fetch_error, 1'b1);
    check("to_req", mem_req, 1'b0);
    redirect_valid = 1'b1; redirect_addr = 8'h00;
    #1;
    check("to_nload", pc_nLoadEnable, 1'b1);
    step(2);
    redirect_valid = 1'b0;
    check("to_req_after", mem_req, 1'b0);
    check("to_err_hold", fetch_error, 1'b1);
`else
    check("nt_err", fetch_error, 1'b0);
    check("nt_req", mem_req, 1'b1);
    check("nt_valid", ir_valid, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
